muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multi-cycle RV M-extension execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage; the decoder routes funct7=0000001 R-type ops here instead of through the ALU control.
- Holds the pipeline through busy until the result is consumed.
- One radix-2 shift-add or restoring-subtract step per cycle.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value
- op_b  input  XLEN  rs2 value
- kill  input  1  pipeline flush; abort the in-flight operation
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes the result
- result  output  XLEN  final result
- busy  output  1  stall request to the hazard unit; high whenever state != IDLE

Behaviour:
- Clock and reset: single clock `clk`. `reset` is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0, all datapath registers=0.
- States:
  - IDLE: in_ready=1. Accept on in_valid&in_ready: latch funct3; latch |op_a|, |op_b| with sign flags (signed ops only; MULHSU treats op_b unsigned); counter=0; go to RUN.
  - RUN: one iteration per edge; counter increments. After the XLEN-th iteration, register the sign-corrected final value into result, set out_valid=1, go to DONE.
  - DONE: result and out_valid held stable until out_ready=1; on that edge out_valid=0, state=IDLE.
  - No new request is accepted in the DONE→IDLE cycle; back-to-back throughput is one op per XLEN+2 cycles.
- Latency: accept at edge E0; out_valid high after edge E_XLEN.
- Multiply:
  - 2*XLEN-bit product register.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Negation is applied on the full 2*XLEN product when the operand signs differ.
- Divide (restoring, unsigned magnitudes):
  - Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
- Divide by zero (op_b=0):
  - DIV/DIVU return all-ones.
  - REM/REMU return op_a unchanged.
  - Still takes XLEN cycles unless early-out is enabled.
- Signed overflow (DIV/REM, op_a = most-negative, op_b = -1):
  - DIV returns op_a; REM returns 0.
  - Explicit override at finalisation.
- kill:
  - In RUN or DONE: next state IDLE, out_valid=0, result unchanged.
  - In IDLE: ignored, and a same-cycle in_valid is NOT accepted.
  - kill takes priority over completion and over out_ready.
- reset mid-operation: identical to reset from IDLE; all outputs go to reset values on that edge.
- in_valid while busy: ignored (in_ready=0); requester must hold the request.
- funct3 and operands are sampled only at accept; later changes have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in IDLE at accept, the special cases finish in one iteration. These are divide by zero, signed overflow, and multiply with op_a=0 or op_b=0. State goes IDLE→RUN→DONE with out_valid high after E1, with the same result values as above.
- Not defined: every operation takes exactly XLEN iterations; special-case results are unchanged.

Test Plan:
- XLEN=32, MUL op_a=7, op_b=-3 (0xFFFFFFFD) → result 0xFFFFFFEB; out_valid rises exactly 32 cycles after accept; busy high throughout.
- XLEN=32, MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- XLEN=32, DIV -7÷2 → 0xFFFFFFFD (-3). REM -7÷2 → 0xFFFFFFFF (-1). DIVU 100÷7 → 14. REMU 100÷7 → 2.
- XLEN=32, DIVU 5÷0 → 0xFFFFFFFF; REM 5÷0 → 5; DIV 0x80000000÷0xFFFFFFFF → 0x80000000; REM of the same → 0. Completion in 32 cycles without MULDIV_EARLY_OUT_EN, in 1 cycle with it.
- Hold out_ready=0 for 10 cycles after completion → result/out_valid stable, in_ready=0, a new in_valid is not accepted. Then out_ready=1 → IDLE on the next edge; the request held since then is accepted one cycle later.
- Assert kill at iteration 10 of a DIV → IDLE next edge, out_valid never rises. Assert reset at iteration 5 of a MUL → all outputs at reset values; a following MUL 3×4 returns 12.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the iterative RV M-extension unit.
interface muldiv_sequencer_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (output in_valid, funct3, op_a, op_b, kill, out_ready,
                    input  in_ready, out_valid, result, busy);
    modport slave  (input  in_valid, funct3, op_a, op_b, kill, out_ready,
                    output in_ready, out_valid, result, busy);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit, one step per clock.
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and zero-operand multiplies in one iteration.
module muldiv_sequencer #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              div_zero_q, div_zero_d;
    logic              ovf_q, ovf_d;
    logic              mul_zero_q, mul_zero_d;
    logic              early_q, early_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic              signed_a_in, signed_b_in;
    logic              neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic              div_zero_in, ovf_in, mul_zero_in;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, step_next, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, orig_a, final_val;
    logic              done_iter;

    // Operand capture: magnitudes plus sign flags, MULHSU keeps op_b unsigned
    always_comb begin
        signed_a_in = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        signed_b_in = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        neg_a_in    = signed_a_in && bus.op_a[XLEN-1];
        neg_b_in    = signed_b_in && bus.op_b[XLEN-1];
        mag_a_in    = neg_a_in ? -bus.op_a : bus.op_a;
        mag_b_in    = neg_b_in ? -bus.op_b : bus.op_b;
        div_zero_in = bus.funct3[2] && (bus.op_b == '0);
        ovf_in      = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                      (bus.op_a == MOST_NEG) && (bus.op_b == '1);
        mul_zero_in = !bus.funct3[2] && ((bus.op_a == '0) || (bus.op_b == '0));
    end

    // One iteration: multiply shifts right and adds, divide shifts left and restores
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
        step_next = funct3_q[2] ? div_next : mul_next;
        done_iter = (cnt_q == CNT_W'(XLEN - 1)) || early_q;
    end

    always_comb begin
        prod_fix  = (sign_a_q ^ sign_b_q) ? -step_next : step_next;
        quo_fix   = (sign_a_q ^ sign_b_q) ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
        rem_fix   = sign_a_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
        orig_a    = sign_a_q ? -a_q : a_q;
        final_val = '0;
        case (funct3_q)
            3'b000:                 final_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_val = quo_fix;
            default:                final_val = rem_fix;
        endcase
        if (mul_zero_q) begin
            final_val = '0;
        end else if (div_zero_q) begin
            final_val = funct3_q[1] ? orig_a : '1;
        end else if (ovf_q) begin
            final_val = funct3_q[1] ? '0 : MOST_NEG;
        end
    end

    // Sequencer: IDLE accepts, RUN iterates, DONE holds the result; kill wins over everything
    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;
        mul_zero_d  = mul_zero_q;
        early_d     = early_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q && !bus.kill) begin
                    state_d    = RUN;
                    funct3_d   = bus.funct3;
                    a_d        = mag_a_in;
                    b_d        = mag_b_in;
                    sign_a_d   = neg_a_in;
                    sign_b_d   = neg_b_in;
                    div_zero_d = div_zero_in;
                    ovf_d      = ovf_in;
                    mul_zero_d = mul_zero_in;
`ifdef MULDIV_EARLY_OUT_EN
                    early_d    = div_zero_in || ovf_in || mul_zero_in;
`else
                    early_d    = 1'b0;
`endif
                    cnt_d      = '0;
                    acc_d      = {{XLEN{1'b0}}, (bus.funct3[2] ? mag_a_in : mag_b_in)};
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                if (bus.kill) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q + 1'b1;
                    if (done_iter) begin
                        state_d     = DONE;
                        result_d    = final_val;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.kill || bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
            mul_zero_q  <= 1'b0;
            early_q     <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
            mul_zero_q  <= mul_zero_d;
            early_q     <= early_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer at XLEN=32 with an arithmetic reference model.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   checking = 1'b0;
    bit   no_valid = 1'b0;
    logic [31:0] exp_result = '0;

    muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference results straight from the ISA definition using wide arithmetic
    function automatic logic [31:0] model_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ub;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'b000: begin p = 64'(sa * sb); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(ia / ib);
            end
            3'b101: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 32'h0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency_for(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (f3[2] && b == 32'h0) ||
                  ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) ||
                  (!f3[2] && (a == 32'h0 || b == 32'h0));
        return (special && EARLY) ? 1 : XLEN;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Per-cycle comparison of the DUT against the model's expectations
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("busy_vs_in_ready", {31'b0, bus.busy}, {31'b0, ~bus.in_ready});
            if (bus.out_valid) begin
                checkOutput("model_result", bus.result, exp_result);
                checkOutput("busy_while_valid", {31'b0, bus.busy}, 32'd1);
            end
            if (no_valid) checkOutput("no_valid_after_kill", {31'b0, bus.out_valid}, 32'd0);
        end
    end

    task automatic startOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("wait_in_ready", {31'b0, bus.in_ready}, 32'd1);
        exp_result   = model_result(f3, a, b);
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
    endtask

    task automatic waitResult(input int lat_exp, input string name);
        int cycles;
        int busy_lo;
        cycles  = 0;
        busy_lo = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
            if (!bus.busy) busy_lo++;
        end while (!bus.out_valid && cycles < 100);
        checkOutput({name, "_latency"}, 32'(cycles), 32'(lat_exp));
        checkOutput({name, "_busy_held"}, 32'(busy_lo), 32'd0);
    endtask

    task automatic drainResult();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("drain_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("drain_in_ready", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expected, input string name);
        startOp(f3, a, b);
        waitResult(latency_for(f3, a, b), name);
        checkOutput({name, "_result"}, bus.result, expected);
        drainResult();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.funct3    = 3'b000;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        reset    = 1'b0;
        checking = 1'b1;

        applyStimulus(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3");
        applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ones");
        applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_ones");
        applyStimulus(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulhsu_m1_2");
        applyStimulus(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_minsq");
        applyStimulus(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mulhsu_min");
        applyStimulus(3'b000, 32'h00000000, 32'h00001234, 32'h00000000, "mul_zero");
        applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2");
        applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2");
        applyStimulus(3'b101, 32'd100,      32'd7,        32'd14,       "divu_100_7");
        applyStimulus(3'b111, 32'd100,      32'd7,        32'd2,        "remu_100_7");
        applyStimulus(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, "divu_by0");
        applyStimulus(3'b110, 32'd5,        32'd0,        32'd5,        "rem_by0");
        applyStimulus(3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, "div_neg_by0");
        applyStimulus(3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, "rem_neg_by0");
        applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");

        // Result held while the consumer stalls; a pending request waits for IDLE
        startOp(3'b000, 32'd3, 32'd5);
        waitResult(XLEN, "mul_3_5");
        checkOutput("mul_3_5_result", bus.result, 32'd15);
        bus.in_valid = 1'b1;
        bus.funct3   = 3'b101;
        bus.op_a     = 32'd100;
        bus.op_b     = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
            checkOutput("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
            checkOutput("hold_result", bus.result, 32'd15);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("release_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
        exp_result = model_result(3'b101, 32'd100, 32'd7);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("held_req_accepted", {31'b0, bus.busy}, 32'd1);
        waitResult(XLEN, "divu_held");
        checkOutput("divu_held_result", bus.result, 32'd14);
        drainResult();

        // kill while idle blocks a same-cycle request
        bus.in_valid = 1'b1;
        bus.kill     = 1'b1;
        bus.funct3   = 3'b000;
        bus.op_a     = 32'd9;
        bus.op_b     = 32'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.kill     = 1'b0;
        checkOutput("idle_kill_in_ready", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("idle_kill_busy", {31'b0, bus.busy}, 32'd0);

        // kill on iteration 10 of a DIV
        startOp(3'b100, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        no_valid = 1'b1;
        checkOutput("kill_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("kill_in_ready", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("kill_result_kept", bus.result, 32'd14);
        repeat (40) @(posedge clk);
        #1;
        no_valid = 1'b0;

        // reset on iteration 5 of a MUL
        startOp(3'b000, 32'h00012345, 32'h00006789);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("midreset_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("midreset_result", bus.result, 32'd0);
        reset = 1'b0;
        applyStimulus(3'b000, 32'd3, 32'd4, 32'd12, "mul_3_4");

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
